// File: rtl/piezo_seq.sv
// piezo_seq: alert tune sequencer and requester arbiter for the piezo PWM generator.
//
// Watches three level-sensitive alert requests, latches the highest-priority one while idle,
// and steps through that alert's note list, driving the PWM period/duty. Every tune is
// followed by a silent rest before another tune may start. An overspeed request preempts a
// lower-priority tune at the next note boundary.
//
// Optional build macro: PIEZO_FAST_SIM_EN scales note/rest lengths by 1/1024 (clamped to a
// minimum of 2 cycles) for fast full-chip simulation. Note frequencies are unchanged.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   too_fast  in   overspeed request (highest priority)
//   batt_low  in   battery-low request (middle priority)
//   en_steer  in   steering-enabled request (lowest priority)
//   max_cnt   out  PWM period minus 1, registered
//   duty      out  PWM high count, registered; 0 = silent
//   tone_on   out  high while a note is sounding
//   busy      out  high while a tune or its rest is in progress
module piezo_seq #(
  parameter int unsigned NOTE_LEN = 6_250_000,
  parameter int unsigned REST_LEN = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        too_fast,
  input  logic        batt_low,
  input  logic        en_steer,
  output logic [20:0] max_cnt,
  output logic [19:0] duty,
  output logic        tone_on,
  output logic        busy
);

`ifdef PIEZO_FAST_SIM_EN
  localparam int unsigned NoteScaled = NOTE_LEN >> 10;
  localparam int unsigned RestScaled = REST_LEN >> 10;
  localparam logic [23:0] NoteLenEff = 24'((NoteScaled < 2) ? 2 : NoteScaled);
  localparam logic [23:0] RestLenEff = 24'((RestScaled < 2) ? 2 : RestScaled);
`else
  localparam logic [23:0] NoteLenEff = 24'(NOTE_LEN);
  localparam logic [23:0] RestLenEff = 24'(REST_LEN);
`endif

  typedef enum logic [1:0] {StIdle, StNote, StRest} state_e;
  typedef enum logic [1:0] {TuneOvr, TuneBatt, TuneSteer} tune_e;
  typedef enum logic [1:0] {NoteC7, NoteE7, NoteG7} note_e;

  state_e      state_q, state_d;
  tune_e       tune_q, tune_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;

  logic [20:0] max_cnt_q, max_cnt_d;
  logic [19:0] duty_q, duty_d;
  logic        tone_on_q, tone_on_d;
  logic        busy_q, busy_d;

  logic [1:0]  last_idx;
  note_e       cur_note;

  // Note list per tune.
  function automatic note_e note_of(tune_e t, logic [1:0] i);
    note_e n;
    n = NoteC7;
    case (t)
      TuneOvr: begin
        case (i)
          2'd0:    n = NoteC7;
          2'd1:    n = NoteE7;
          default: n = NoteG7;
        endcase
      end
      TuneBatt: begin
        case (i)
          2'd0:    n = NoteG7;
          2'd1:    n = NoteE7;
          default: n = NoteC7;
        endcase
      end
      default: n = (i == 2'd0) ? NoteC7 : NoteG7;
    endcase
    return n;
  endfunction

  assign last_idx = (tune_q == TuneSteer) ? 2'd1 : 2'd2;
  assign cur_note = note_of(tune_q, idx_q);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    tune_d  = tune_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (too_fast || batt_low || en_steer) begin
          if (too_fast)      tune_d = TuneOvr;
          else if (batt_low) tune_d = TuneBatt;
          else               tune_d = TuneSteer;
          idx_d   = 2'd0;
          cnt_d   = NoteLenEff - 24'd1;
          state_d = StNote;
        end
      end
      StNote: begin
        if (cnt_q == 24'd0) begin
          // Preemption is only considered at a note boundary.
          if (tune_q != TuneOvr && too_fast) begin
            tune_d = TuneOvr;
            idx_d  = 2'd0;
            cnt_d  = NoteLenEff - 24'd1;
          end else if (idx_q != last_idx) begin
            idx_d = idx_q + 2'd1;
            cnt_d = NoteLenEff - 24'd1;
          end else begin
            cnt_d   = RestLenEff - 24'd1;
            state_d = StRest;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      StRest: begin
        if (cnt_q == 24'd0) state_d = StIdle;
        else                cnt_d   = cnt_q - 24'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output registers follow the current state, so outputs lag the state by one edge.
  always_comb begin
    max_cnt_d = '0;
    duty_d    = '0;
    tone_on_d = 1'b0;
    busy_d    = 1'b0;
    if (state_q == StNote) begin
      tone_on_d = 1'b1;
      busy_d    = 1'b1;
      case (cur_note)
        NoteC7: begin
          max_cnt_d = 21'd23888;
          duty_d    = 20'd11944;
        end
        NoteE7: begin
          max_cnt_d = 21'd18960;
          duty_d    = 20'd9480;
        end
        default: begin
          max_cnt_d = 21'd15943;
          duty_d    = 20'd7972;
        end
      endcase
    end else if (state_q == StRest) begin
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tune_q    <= TuneOvr;
      idx_q     <= 2'd0;
      cnt_q     <= 24'd0;
      max_cnt_q <= '0;
      duty_q    <= '0;
      tone_on_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tune_q    <= tune_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      max_cnt_q <= max_cnt_d;
      duty_q    <= duty_d;
      tone_on_q <= tone_on_d;
      busy_q    <= busy_d;
    end
  end

  assign max_cnt = max_cnt_q;
  assign duty    = duty_q;
  assign tone_on = tone_on_q;
  assign busy    = busy_q;

endmodule

// File: doc/piezo_seq.md
# piezo_seq

Tune sequencer and requester arbiter for the Segway piezo driver. Watches three alert requests (overspeed, battery low, steering enabled), picks one by fixed priority, and steps through that alert's note list, driving `max_cnt`/`duty` of the piezo PWM generator. Silence is `duty = 0`, which holds the PWM output low. Sits between the top-level status logic and the piezo PWM instance.

## Interface
- `NOTE_LEN`, default 6_250_000: clock cycles per note (125 ms at 50 MHz); 24-bit, minimum 2.
- `REST_LEN`, default 12_500_000: silent cycles after every tune before the next tune may start; 24-bit, minimum 1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `too_fast`  in  1  overspeed request, level-sensitive; highest priority.
- `batt_low`  in  1  battery-low request, level-sensitive; middle priority.
- `en_steer`  in  1  steering-enabled request, level-sensitive; lowest priority.
- `max_cnt`  out  21  PWM period minus 1, registered.
- `duty`  out  20  PWM high count, registered; 0 means silent.
- `tone_on`  out  1  high while a note is sounding.
- `busy`  out  1  high in NOTE or REST.

## Operation
- Note periods at 50 MHz, as `max_cnt` / `duty`:
  - C7: 23888 / 11944.
  - E7: 18960 / 9480.
  - G7: 15943 / 7972.
  - In general, `duty = (max_cnt+1)>>1`.
- Tunes:
  - OVR (`too_fast`): C7, E7, G7.
  - BATT (`batt_low`): G7, E7, C7.
  - STEER (`en_steer`): C7, G7.
- States: IDLE, NOTE, REST.
- IDLE:
  - Outputs silent (`max_cnt=0`, `duty=0`).
  - If any request is high, latch the highest-priority one as the tune.
  - Set note index 0 and load the duration counter with NOTE_LEN-1, then go to NOTE.
- NOTE:
  - Drive the current note's values and hold `tone_on=1`.
  - The duration counter decrements each cycle.
  - At 0:
    - If the current tune is not OVR and `too_fast=1`, preempt: switch tune to OVR, set index 0, reload NOTE_LEN-1, stay in NOTE.
    - Else, if more notes remain, advance the index and reload.
    - Else, load REST_LEN-1 and go to REST.
  - Preemption is checked only at note boundaries, never mid-note.
- REST:
  - Outputs silent, `tone_on=0`.
  - Counter decrements; at 0 go to IDLE.
  - Requests are ignored during REST.
- A request held high therefore replays its tune once every tune length plus REST_LEN plus 1 cycle.
- Requests deasserted mid-tune do not abort it; the tune finishes.
- Counter width is 24 bits. The decrement never wraps, because reload happens at 0.

## Timing
- All outputs are registered. Reset values: `max_cnt=0`, `duty=0`, `tone_on=0`, `busy=0`, state IDLE.
- Request high in IDLE at edge N: first note values, `tone_on=1` and `busy=1` appear after edge N+1.
- Each note is held for exactly NOTE_LEN cycles. The next note's values replace it on the following edge, with no silent cycle between notes.
- After the last note: `duty=0` and `tone_on=0` for exactly REST_LEN cycles, then one IDLE cycle before any new tune.
- `rst_n=0` sampled at any edge, mid-note or mid-rest, returns everything to reset values on that edge. The tune is lost, not resumed.
- Simultaneous requests in IDLE: priority is `too_fast` > `batt_low` > `en_steer`.

## Configuration
- `PIEZO_FAST_SIM_EN`:
  - When defined, effective note and rest lengths are `NOTE_LEN>>10` and `REST_LEN>>10`, each clamped to a minimum of 2. This gives fast full-chip simulation.
  - When undefined, the parameters are used unscaled.
- Note frequencies (`max_cnt`/`duty`) are identical in both builds.

## Test plan
- Reset, with `NOTE_LEN=8` and `REST_LEN=4`: all outputs 0 and `busy=0`. Hold `rst_n=0` with requests high: outputs stay 0.
- `en_steer` pulsed high 1 cycle in IDLE -> `max_cnt=23888` for 8 cycles, then 15943 for 8 cycles, then `duty=0` for 4 cycles. `busy` falls after 21 cycles, and no replay follows.
- `too_fast`, `batt_low` and `en_steer` all high on the same cycle -> notes 23888, 18960, 15943 (OVR), replaying every 29 cycles while `too_fast` stays high.
- `batt_low` tune running, `too_fast` rises mid-note 0 -> note 0 (15943) completes its full 8 cycles, then 23888, 18960, 15943 follow, then rest.
- `rst_n` low during note 1 of BATT -> next cycle `duty=0`, `tone_on=0`, `busy=0`. After release with no requests, the block stays idle.
- `PIEZO_FAST_SIM_EN` defined, defaults -> notes last 6103 cycles and rests last 12207 cycles.
